// File: rtl/jb_pkg.sv
// jb_pkg: shared constants for the jump/branch unit.
//   OPC_*  : 5-bit instruction class codes that resolve as jumps/branches.
//   FLAG_* : 2-bit compare result encodings from the compare stage.
package jb_pkg;

    localparam logic [4:0] OPC_JMP = 5'b11000;
    localparam logic [4:0] OPC_BEQ = 5'b11001;
    localparam logic [4:0] OPC_BL  = 5'b11010;
    localparam logic [4:0] OPC_BG  = 5'b11011;

    localparam logic [1:0] FLAG_NONE = 2'b00;
    localparam logic [1:0] FLAG_EQ   = 2'b01;
    localparam logic [1:0] FLAG_LT   = 2'b10;
    localparam logic [1:0] FLAG_GT   = 2'b11;

endpackage

// File: rtl/jb_cond.sv
// jb_cond: combinational take-condition decode.
// Ports:
//   opcode (in, 5)  instruction class code
//   flag   (in, 2)  compare result
//   take   (out, 1) branch condition satisfied
module jb_cond
    import jb_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [1:0] flag,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        unique case (opcode)
            OPC_JMP: take = 1'b1;
            OPC_BEQ: take = (flag == FLAG_EQ);
            OPC_BL:  take = (flag == FLAG_LT);
            OPC_BG:  take = (flag == FLAG_GT);
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/jb_unit.sv
// jb_unit: resolves jump/branch instructions with one cycle of latency.
// Optional feature macro: JB_MISALIGN_CHECK_EN (adds misalign output and
// suppresses jumps to targets that are not word aligned).
// Ports:
//   clk           (in, 1)     clock, rising edge
//   reset         (in, 1)     synchronous active-high reset
//   opcode        (in, 5)     instruction class code
//   pc_current    (in, XLEN)  PC of the instruction being resolved
//   imm_ext       (in, XLEN)  sign-extended offset
//   flag          (in, 2)     compare result
//   branch_target (out, XLEN) registered pc_current + imm_ext
//   jump          (out, 1)    registered take-branch strobe
//   misalign      (out, 1)    registered misaligned-target flag (macro only)
module jb_unit
    import jb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      opcode,
    input  logic [XLEN-1:0] pc_current,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [1:0]      flag,
`ifdef JB_MISALIGN_CHECK_EN
    output logic            misalign,
`endif
    output logic [XLEN-1:0] branch_target,
    output logic            jump
);

    logic            take;
    logic [XLEN-1:0] target_d, target_q;
    logic            jump_d, jump_q;

    jb_cond u_cond (
        .opcode (opcode),
        .flag   (flag),
        .take   (take)
    );

    // Plain XLEN-bit add: carry out is dropped, giving two's-complement wrap.
    assign target_d = pc_current + imm_ext;

`ifdef JB_MISALIGN_CHECK_EN
    logic misalign_d, misalign_q;

    always_comb begin
        misalign_d = take & (target_d[1:0] != 2'b00);
        jump_d     = take & ~misalign_d;
    end

    always_ff @(posedge clk) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end

    assign misalign = misalign_q;
`else
    assign jump_d = take;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= '0;
            jump_q   <= 1'b0;
        end else begin
            target_q <= target_d;
            jump_q   <= jump_d;
        end
    end

    assign branch_target = target_q;
    assign jump          = jump_q;

endmodule

// File: tb/tb_jb_unit.sv
// tb_jb_unit: directed and randomized checks of jb_unit against a
// behavioural model computed from the instruction rules.
module tb_jb_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  opcode;
    logic [31:0] pc_current;
    logic [31:0] imm_ext;
    logic [1:0]  flag;
    logic [31:0] branch_target;
    logic        jump;
`ifdef JB_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int checks = 0;
    int errors = 0;

    jb_unit #(.XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .pc_current    (pc_current),
        .imm_ext       (imm_ext),
        .flag          (flag),
`ifdef JB_MISALIGN_CHECK_EN
        .misalign      (misalign),
`endif
        .branch_target (branch_target),
        .jump          (jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Condition from the instruction table: which flag value (if any) is needed.
    function automatic bit model_take(input logic [4:0] op, input logic [1:0] f);
        if (op == 5'd24) return 1'b1;            // JMP
        if (op == 5'd25) return f == 2'd1;       // BEQ needs equal
        if (op == 5'd26) return f == 2'd2;       // BL needs less
        if (op == 5'd27) return f == 2'd3;       // BG needs greater
        return 1'b0;
    endfunction

    // Apply one set of inputs, clock once, compare against the model.
    task automatic step(input string tag, input logic r, input logic [4:0] op,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [1:0] f);
        longint unsigned sum;
        logic [31:0]     exp_tgt;
        logic            exp_jump;
        logic            exp_mis;
        reset      = r;
        opcode     = op;
        pc_current = pc;
        imm_ext    = imm;
        flag       = f;
        sum      = longint'(pc) + longint'(imm);
        exp_tgt  = r ? 32'd0 : 32'(sum % 64'h1_0000_0000);
        exp_jump = !r && model_take(op, f);
        exp_mis  = 1'b0;
`ifdef JB_MISALIGN_CHECK_EN
        if (exp_jump && (exp_tgt % 4 != 0)) begin
            exp_mis  = 1'b1;
            exp_jump = 1'b0;
        end
`endif
        @(posedge clk);
        #1;
        check_eq({tag, ".target"}, branch_target, exp_tgt);
        check_eq({tag, ".jump"}, {31'd0, jump}, {31'd0, exp_jump});
`ifdef JB_MISALIGN_CHECK_EN
        check_eq({tag, ".misalign"}, {31'd0, misalign}, {31'd0, exp_mis});
`else
        if (exp_mis) check_eq({tag, ".misalign_unexpected"}, 32'd1, 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1; opcode = '0; pc_current = '0; imm_ext = '0; flag = '0;

        step("reset_hold", 1'b1, 5'b11000, 32'd100, 32'd4, 2'b00);
        step("jmp",        1'b0, 5'b11000, 32'd100, 32'd4, 2'b00);
        step("beq_eq",     1'b0, 5'b11001, 32'd100, 32'd4, 2'b01);
        step("beq_none",   1'b0, 5'b11001, 32'd100, 32'd4, 2'b00);
        step("bl_lt",      1'b0, 5'b11010, 32'd100, 32'd4, 2'b10);
        step("bg_gt",      1'b0, 5'b11011, 32'd100, 32'd4, 2'b11);
        step("bl_gt",      1'b0, 5'b11010, 32'd100, 32'd4, 2'b11);
        step("bg_lt",      1'b0, 5'b11011, 32'd100, 32'd4, 2'b10);
        step("opc_zero",   1'b0, 5'b00000, 32'd100, 32'd4, 2'b01);
        step("wrap",       1'b0, 5'b11000, 32'hFFFF_FFFC, 32'd8, 2'b00);
        step("neg_off",    1'b0, 5'b11000, 32'd100, 32'hFFFF_FFF8, 2'b00);
        step("misalign",   1'b0, 5'b11000, 32'd100, 32'd2, 2'b00);
        // Back-to-back taken then not-taken: no sticky strobe.
        step("b2b_take",   1'b0, 5'b11000, 32'd200, 32'd16, 2'b00);
        step("b2b_drop",   1'b0, 5'b11011, 32'd200, 32'd16, 2'b00);
        // Reset in mid-stream discards the in-flight result.
        step("mid_reset",  1'b1, 5'b11000, 32'd300, 32'd12, 2'b00);
        step("post_reset", 1'b0, 5'b11001, 32'd400, 32'd20, 2'b01);
        // Inputs that glitch between edges are not seen.
        #2;
        opcode = 5'b11000; pc_current = 32'hDEAD_BEEF; imm_ext = 32'd1;
        #2;
        step("glitch",     1'b0, 5'b11010, 32'd64, 32'd8, 2'b01);

        for (int i = 0; i < 300; i++) begin
            logic [4:0] op;
            logic [31:0] imm;
            op  = ($urandom_range(0, 3) != 0) ? 5'(5'd24 + $urandom_range(0, 3))
                                              : 5'($urandom);
            imm = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'(4 * $urandom_range(0, 64));
            step("rand", ($urandom_range(0, 19) == 0), op, 32'($urandom), imm, 2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jb_unit.md
JB_UNIT -- requirements
Module: jb_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, the address and immediate width; all behaviour below is specified at XLEN=32.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port opcode, input, 5 bits, the instruction class code.
REQ-005 SHALL have port pc_current, input, XLEN bits, the PC of the instruction being resolved.
REQ-006 SHALL have port imm_ext, input, XLEN bits, the sign-extended offset.
REQ-007 SHALL have port flag, input, 2 bits, the compare result: 00 none, 01 equal, 10 less, 11 greater.
REQ-008 SHALL have port branch_target, output, XLEN bits, the registered target address.
REQ-009 SHALL have port jump, output, 1 bit, the registered take-branch strobe.
REQ-010 SHALL have port misalign, output, 1 bit, present only when JB_MISALIGN_CHECK_EN is defined.

Function
REQ-011 SHALL compute the next target as pc_current + imm_ext modulo 2^XLEN: two's-complement wrap, no carry out, negative offsets allowed.
REQ-012 SHALL decode the take condition as follows:
- JMP (11000): always taken.
- BEQ (11001): taken iff flag==01.
- BL (11010): taken iff flag==10.
- BG (11011): taken iff flag==11.
- Any other opcode: not taken.
REQ-013 SHALL register jump and branch_target on every rising edge, giving exactly one cycle of latency from a stable input to the output.
REQ-014 SHALL update branch_target every cycle with the computed sum, whether or not the branch is taken.
REQ-015 SHALL hold jump high for each cycle in which the sampled inputs satisfy the condition; there is no handshake and no sticky state.
REQ-016 SHALL treat back-to-back jump opcodes independently, each resolved by its own cycle's inputs.
REQ-017 SHALL treat input changes between clock edges as invisible; only values at the rising edge matter.

Reset
REQ-018 SHALL, while reset is high at a rising edge, force branch_target=0, jump=0 and misalign=0 (when present), overriding all inputs.
REQ-019 SHALL make reset asserted mid-operation discard the in-flight result; the first post-reset output reflects inputs sampled at the first edge with reset low.

Configuration
REQ-020 SHALL, when JB_MISALIGN_CHECK_EN is defined:
- add output misalign.
- register misalign=1 when the condition is met and target[1:0]!=00.
- force jump=0 in that same cycle.
- keep branch_target at the computed sum.
REQ-021 SHALL, when JB_MISALIGN_CHECK_EN is undefined, omit the misalign port and ignore target alignment.

Structure
REQ-022 SHALL place the opcode constants (OPC_JMP, OPC_BEQ, OPC_BL, OPC_BG) and the flag encodings (FLAG_NONE, FLAG_EQ, FLAG_LT, FLAG_GT) in shared package jb_pkg.
REQ-023 SHALL implement the condition decode as combinational sub-module jb_cond (inputs opcode and flag, output take); the adder and output registers stay in jb_unit.

Verification
REQ-024 SHALL cover: reset=1, pc=100, imm=4 -> branch_target=0, jump=0.
REQ-025 SHALL cover: opcode=11000, pc=100, imm=4, flag=00 -> after one edge, branch_target=104, jump=1.
REQ-026 SHALL cover:
- BEQ with flag=01 -> jump=1, target=104.
- BEQ with flag=00 -> jump=0, target=104.
REQ-027 SHALL cover:
- BL with flag=10 -> jump=1.
- BG with flag=11 -> jump=1.
- BL with flag=11 -> jump=0.
- BG with flag=10 -> jump=0.
- opcode=00000 -> jump=0.
REQ-028 SHALL cover:
- Wrap: pc=0xFFFFFFFC, imm=8, JMP -> target=0x00000004.
- Negative offset: pc=100, imm=0xFFFFFFF8, JMP -> target=92.
REQ-029 SHALL cover, with JB_MISALIGN_CHECK_EN defined: pc=100, imm=2, JMP -> jump=0, misalign=1, target=102.
